mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words in the backing array.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, range 0..15, meaning the extra cycles between request accept and response valid.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have the following request-side ports:
- req_valid, input, 1 bit: the initiator presents a request.
- req_ready, output, 1 bit: the responder can accept a request.
- req_we, input, 1 bit: 1 = write, 0 = read.
- req_addr, input, 32 bits: byte address.
- req_wdata, input, 32 bits: write data.
- req_be, input, 4 bits: byte enables; bit i covers wdata[8i+7:8i].
REQ-006 The block SHALL have the following response-side ports:
- rsp_valid, output, 1 bit: a response is presented.
- rsp_ready, input, 1 bit: the initiator accepts the response.
- rsp_rdata, output, 32 bits: read data.
- rsp_err, output, 1 bit: the request was misaligned or out of range.

Function
REQ-007 The block SHALL implement FSM states IDLE, WAIT and RESP.
REQ-008 req_ready SHALL be 1 only in IDLE.
REQ-009 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-010 On accept, the block SHALL latch req_we, req_addr, req_wdata and req_be.
REQ-011 On accept, the FSM SHALL move to WAIT if WAIT_CYCLES>0, otherwise directly to RESP.
REQ-012 In WAIT, a 4-bit down-counter loaded with WAIT_CYCLES-1 at accept SHALL decrement each cycle; the FSM SHALL move to RESP on the edge where the counter is 0.
REQ-013 Latency from the accept edge to rsp_valid=1 SHALL be exactly WAIT_CYCLES+1 cycles, with the first cycle after accept counted as 1.
REQ-014 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1.
REQ-015 The FSM SHALL return to IDLE on the edge where rsp_valid=1 and rsp_ready=1.
REQ-016 There SHALL be at most one outstanding request, leaving a minimum one-cycle bubble between back-to-back transactions.
REQ-017 rsp_err SHALL be 1 when latched addr[1:0]!=0 or addr[31:2]>=DEPTH.
REQ-018 On error, the block SHALL perform no array write and SHALL drive rsp_rdata=0.
REQ-019 A valid write SHALL update only the enabled bytes of word addr[31:2], committed on the accept edge.
REQ-020 On a valid write, rsp_rdata SHALL be 0.
REQ-021 A write with req_be=0 SHALL be legal: no array change, rsp_err=0.
REQ-022 A valid read SHALL sample the array word on the edge entering RESP.
REQ-023 A read SHALL return data that reflects all previously completed writes (read-after-write coherent).
REQ-024 req_valid asserted outside IDLE SHALL be ignored without side effects; the initiator holds it until accepted.
REQ-025 rsp_ready asserted outside RESP SHALL be ignored.
REQ-026 rsp_ready=1 already asserted on the cycle rsp_valid rises SHALL complete the response in that single cycle.
REQ-027 Address bits above those needed to index DEPTH SHALL participate only in the range check; there SHALL be no wrap-around aliasing.

Reset
REQ-028 While rst_n=0, the FSM SHALL be IDLE, the counter 0, and req_ready=0.
REQ-029 While rst_n=0, rsp_valid, rsp_err and rsp_rdata SHALL be 0.
REQ-030 The first cycle after rst_n deasserts, req_ready SHALL be 1.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no response; a write already committed at accept SHALL remain in the array.
REQ-032 Array contents SHALL NOT be reset.

Structure
REQ-033 The state enum (IDLE, WAIT, RESP), data width 32 and byte-enable width 4 SHALL live in the shared package mem_pkg, imported by this block and by the core controller.
REQ-034 Storage SHALL be a sub-module mem_array: DEPTH x 32, one synchronous write port with byte enables, one read port.
REQ-035 The FSM, counter, latches and error check SHALL reside in mem_responder.

Verification
REQ-036 Scenario: WAIT_CYCLES=1; write addr 0x10, data 0xDEADBEEF, be 0xF, then read 0x10 -> rsp_valid 2 cycles after each accept; read rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-037 Scenario: write 0x11223344 to 0x20; write be=0x2, data 0x0000AA00 to 0x20; read 0x20 -> 0x1122AA44.
REQ-038 Scenario: read addr 0x3 and read addr DEPTH*4 -> rsp_err=1, rsp_rdata=0; a subsequent read of word 0 is unchanged.
REQ-039 Scenario: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable all 5 cycles; req_ready=0 throughout.
REQ-040 Scenario: WAIT_CYCLES=0 with rsp_ready tied 1 -> rsp_valid 1 cycle after accept, req_ready back to 1 the following cycle.
REQ-041 Scenario: rst_n pulsed low during WAIT of a read -> no rsp_valid; req_ready=1 the first cycle after release; earlier writes intact.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM states, bus widths, the latched
// request record and the address legality check.
package mem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } req_t;

    // All 30 word-address bits take part in the range check, so high bits
    // can never alias back onto a valid word.
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[ADDR_W-1:2]} >= depth);
    endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x 32 storage: one synchronous byte-enabled write port and one
// combinational read port. Contents are never reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request, commits writes at
// accept, waits WAIT_CYCLES, then holds a response until the initiator takes it.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_q;
    logic [3:0]        cnt_q;
    req_t              req_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    req_t              req_in;
    req_t              cur;
    logic              accept;
    logic              cur_err;
    logic              arr_we;
    logic [IDX_W-1:0]  cur_idx;
    logic [DATA_W-1:0] arr_rdata;
    logic [DATA_W-1:0] rsp_rdata_d;

    assign req_in = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

    // In IDLE the live request is the one being accepted; afterwards the
    // latched copy is authoritative. One view feeds both array ports.
    assign cur     = (state_q == IDLE) ? req_in : req_q;
    assign cur_err = addr_err(cur.addr, DEPTH);
    assign cur_idx = cur.addr[IDX_W+1:2];

    assign req_ready = (state_q == IDLE) && rst_n;
    assign accept    = req_valid && req_ready;
    assign arr_we    = accept && cur.we && !cur_err;

    assign rsp_rdata_d = (cur.we || cur_err) ? '0 : arr_rdata;

    mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .waddr_i (cur_idx),
        .wdata_i (cur.wdata),
        .be_i    (cur.be),
        .raddr_i (cur_idx),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_q <= req_in;
                        if (WAIT_CYCLES == 0) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= cur_err;
                            rsp_rdata_q <= rsp_rdata_d;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    // Read data is sampled here, on the edge entering RESP.
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= cur_err;
                        rsp_rdata_q <= rsp_rdata_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: cycle-level reference model plus a few
// hand-computed scenarios, and a WAIT_CYCLES=0 instance with rsp_ready tied high.
module tb_mem_responder;

    localparam int DEPTH = 64;
    localparam int W     = 1;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        r0_valid, r0_ready, r0_we, v0, e0;
    logic [31:0] r0_addr, r0_wdata, d0;
    logic [3:0]  r0_be;

    int nchk  = 0;
    int npass = 0;

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(r0_valid), .req_ready(r0_ready), .req_we(r0_we),
        .req_addr(r0_addr), .req_wdata(r0_wdata), .req_be(r0_be),
        .rsp_valid(v0), .rsp_ready(1'b1),
        .rsp_rdata(d0), .rsp_err(e0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mem_m [DEPTH];
    int          cyc     = 0;
    bit          busy    = 0;
    int          resp_at = 0;
    logic [31:0] exp_rdata = '0;
    bit          exp_err   = 0;

    function automatic bit is_err(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= DEPTH);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    initial for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            busy <= 0;
        end else if (!busy && req_valid) begin
            busy    <= 1;
            resp_at <= cyc + W + 1;
            exp_err <= is_err(req_addr);
            if (is_err(req_addr)) begin
                exp_rdata <= '0;
            end else if (req_we) begin
                exp_rdata <= '0;
                mem_m[req_addr / 4] <= merge(mem_m[req_addr / 4], req_wdata, req_be);
            end else begin
                exp_rdata <= mem_m[req_addr / 4];
            end
        end else if (busy && cyc >= resp_at && rsp_ready) begin
            busy <= 0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
            chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
            chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
        end else begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, !busy});
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, busy && cyc >= resp_at});
            if (busy && cyc >= resp_at) begin
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_err",   {31'd0, rsp_err}, {31'd0, exp_err});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic junkify();
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    // hold < 0: random rsp_ready; hold >= 0: rsp_ready low for the first hold valid cycles.
    task automatic xact(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int hold, input bit junk,
                        output logic [31:0] rd, output bit er, output int lat);
        bit acc, done;
        int vcnt;
        logic [31:0] d_first;
        bit e_first;
        req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        rsp_ready = (hold < 0) ? 1'($urandom) : (hold == 0);
        acc = 0;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = req_ready;
            tick();
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        req_valid = junk;
        if (junk) junkify();
        lat = 0; done = 0; vcnt = 0; rd = '0; er = 0;
        d_first = '0; e_first = 0;
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                if (vcnt == 0) begin
                    lat = k; d_first = rsp_rdata; e_first = rsp_err;
                end else if (hold > 0) begin
                    chk("hold_rdata", rsp_rdata, d_first);
                    chk("hold_err", {31'd0, rsp_err}, {31'd0, e_first});
                    chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
                end
                vcnt++;
                if (rsp_ready) begin
                    rd = rsp_rdata; er = rsp_err; done = 1;
                end
            end
            tick();
            if (junk) junkify();
            rsp_ready = (hold < 0) ? 1'($urandom) : (vcnt >= hold);
        end
        req_valid = 0; rsp_ready = 0;
        if (!done) chk("rsp_timeout", 32'd0, 32'd1);
        if (hold > 0) chk("hold_valid_cycles", 32'(vcnt), 32'(hold + 1));
    endtask

    task automatic w0_op(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_d);
        tick();
        r0_valid = 1; r0_we = we; r0_addr = a; r0_wdata = d; r0_be = 4'hF;
        @(negedge clk);
        chk("w0_ready_idle", {31'd0, r0_ready}, 32'd1);
        tick();
        r0_valid = 0;
        @(negedge clk);
        chk("w0_valid_lat1", {31'd0, v0}, 32'd1);
        chk("w0_ready_busy", {31'd0, r0_ready}, 32'd0);
        chk("w0_rdata", d0, exp_d);
        chk("w0_err", {31'd0, e0}, 32'd0);
        @(negedge clk);
        chk("w0_ready_back", {31'd0, r0_ready}, 32'd1);
        chk("w0_valid_drop", {31'd0, v0}, 32'd0);
    endtask

    logic [31:0] rd;
    bit          er;
    int          lat;

    initial begin
        rst_n = 0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 0;
        r0_valid = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0; r0_be = '0;
        repeat (3) tick();
        rst_n = 1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

        // Zero-wait instance with rsp_ready tied high
        w0_op(1, 32'h14, 32'hA5A5_0F0F, 32'h0);
        w0_op(0, 32'h14, 32'h0, 32'hA5A5_0F0F);

        // Preload every word so the array has known contents
        for (int i = 0; i < DEPTH; i++) xact(1, 32'(i * 4), $urandom, 4'hF, -1, 0, rd, er, lat);

        xact(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, rd, er, lat);
        chk("wr10_lat", 32'(lat), 32'd2);
        chk("wr10_rdata", rd, 32'd0);
        xact(0, 32'h10, 32'h0, 4'hF, 0, 0, rd, er, lat);
        chk("rd10_lat", 32'(lat), 32'd2);
        chk("rd10_rdata", rd, 32'hDEAD_BEEF);
        chk("rd10_err", {31'd0, er}, 32'd0);

        xact(1, 32'h20, 32'h1122_3344, 4'hF, -1, 0, rd, er, lat);
        xact(1, 32'h20, 32'h0000_AA00, 4'h2, -1, 1, rd, er, lat);
        xact(1, 32'h20, 32'hFFFF_FFFF, 4'h0, -1, 0, rd, er, lat);
        chk("be0_err", {31'd0, er}, 32'd0);
        xact(0, 32'h20, 32'h0, 4'hF, -1, 0, rd, er, lat);
        chk("rd20_merge", rd, 32'h1122_AA44);

        xact(1, 32'h0, 32'hCAFE_F00D, 4'hF, -1, 0, rd, er, lat);
        xact(0, 32'h3, 32'h0, 4'hF, -1, 0, rd, er, lat);
        chk("rd3_err", {31'd0, er}, 32'd1);
        chk("rd3_rdata", rd, 32'd0);
        xact(0, 32'(DEPTH * 4), 32'h0, 4'hF, -1, 0, rd, er, lat);
        chk("rd_oor_err", {31'd0, er}, 32'd1);
        chk("rd_oor_rdata", rd, 32'd0);
        xact(1, 32'(DEPTH * 4), 32'h1234_5678, 4'hF, -1, 0, rd, er, lat);
        chk("wr_alias_err", {31'd0, er}, 32'd1);
        xact(1, 32'h1, 32'h1234_5678, 4'hF, -1, 0, rd, er, lat);
        xact(0, 32'h0, 32'h0, 4'hF, -1, 0, rd, er, lat);
        chk("rd0_unchanged", rd, 32'hCAFE_F00D);

        xact(0, 32'h10, 32'h0, 4'hF, 5, 0, rd, er, lat);
        chk("hold_final_rdata", rd, 32'hDEAD_BEEF);

        // Reset during WAIT of a read, then of a write
        for (int t = 0; t < 2; t++) begin
            tick();
            req_valid = 1; req_we = (t == 1); req_addr = 32'h30;
            req_wdata = 32'h0BAD_CAFE; req_be = 4'hF;
            begin
                bit acc;
                acc = 0;
                for (int n = 0; n < 20 && !acc; n++) begin
                    @(negedge clk); acc = req_ready; tick();
                end
                if (!acc) chk("rst_accept_timeout", 32'd0, 32'd1);
            end
            req_valid = 0; rst_n = 0;
            repeat (3) tick();
            rst_n = 1;
            @(negedge clk);
            chk("ready_first_after_release", {31'd0, req_ready}, 32'd1);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("no_rsp_after_reset", {31'd0, rsp_valid}, 32'd0);
            end
        end
        xact(0, 32'h30, 32'h0, 4'hF, -1, 0, rd, er, lat);
        chk("write_survives_reset", rd, 32'h0BAD_CAFE);
        xact(0, 32'h10, 32'h0, 4'hF, -1, 0, rd, er, lat);
        chk("old_write_intact", rd, 32'hDEAD_BEEF);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int r, idx;
            logic [31:0] a;
            r = int'($urandom_range(0, 7));
            idx = int'($urandom_range(0, DEPTH - 1));
            if (r <= 4)      a = 32'(idx * 4);
            else if (r == 5) a = 32'(idx * 4) + 32'($urandom_range(1, 3));
            else if (r == 6) a = 32'(idx * 4) + 32'(DEPTH * 4) * 32'($urandom_range(1, 1000));
            else             a = 32'hFFFF_FFFC;
            xact(1'($urandom), a, $urandom,
                 ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom),
                 ($urandom_range(0, 3) == 0) ? 0 : -1, 1'($urandom), rd, er, lat);
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
